bus_datapath: RTL and testbench
===============================

Name: bus_datapath

Overview:
- 32-bit single-bus CPU datapath.
- Contents: 16 general registers, HI/LO, 64-bit Z, PC, IR, MAR, MDR, input port, output port, a sign-extended constant source, and a small ALU, all sharing one 32-bit bus.
- A control unit or testbench drives all enable/select strobes directly; the block contains no sequencing logic.

Parameters:
- WIDTH, 32, datapath and register width.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset: one clock; reset is asynchronous and active-high (clr); clears every register to 0.
- MDRRead  in  1  MDR input source: 1 = MDRMDataIn (memory), 0 = bus.
- ALUen  in  1  1 = Z loads the ALU result; 0 = Z loads the bus value zero-extended.
- incPC  in  1  with PCins: PC <= PC+1 instead of the bus.
- BAOut  in  1  with R0out: drive 0 instead of R0 (base-address zero rule).
- R0out..R14out, R20out, HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InportOut, Cout  in  1 each  bus source selects. R20 is the 16th general register.
- r0ins..r14ins, r20ins, HIins, LOins, ZHIins, ZLOins, PCins, MDRins, MARins, Inports, Outports, IRins  in  1 each  register load enables.
- MDRMDataIn  in  32  memory data into MDR; also the external input-port data.
- OutportOut  out  32  output-port register contents.

Behaviour:
- All registers are posedge, load on their enable, clear asynchronously on clr. Reset value of every register and of OutportOut is 0.
- Bus mux (combinational) uses a fixed priority when several selects are active:
  - R0..R14, R20, HI, LO, ZHI, ZLO, PC, MDR, Inport, C.
  - No select active: bus = 0.
- R0out && BAOut: bus = 0.
- Cout: bus = sign-extend(IR[18:0]).
- Inports: Inport <= MDRMDataIn.
- Outports: Outport <= bus; OutportOut = Outport.
- MDRins: MDR <= (MDRRead ? MDRMDataIn : bus).
- MARins: MAR <= bus. MAR is internal only.
- IRins: IR <= bus.
- PCins: PC <= incPC ? PC+1 : bus. incPC without PCins has no effect.
- ALU, combinational:
  - Operands: A = register file[IR[22:19]], where index 15 maps to R20; B = bus.
  - Operation by IR[31:27]:
    - 00011 add
    - 00100 sub
    - 00101 and
    - 00110 or
    - 00111 shr logical by B[4:0]
    - 01001 shl by B[4:0]
    - 10001 neg B
    - 10010 not B
    - any other opcode (incl. ld 10100, st 10110): add.
  - Result is 64-bit:
    - add/sub: sign-extended 33-bit result, with carry captured in bit 32 and bits above sign-extended.
    - All other ops: high word = 0.
- ZLOins loads Z[31:0]; ZHIins loads Z[63:32]; the source is the ALU result when ALUen=1, else {32'b0, bus}.
- Simultaneous load and read of the same register: the read sees the old value; the new value appears after the edge.
- clr asserted mid-operation clears immediately, independent of clk. Loads are ignored while clr is high.
- Arithmetic wraps modulo 2^32 in the low word; there are no flags.

Decomposition:
- Shared package: opcode constants (ADD, SUB, AND, OR, SHR, SHL, NEG, NOT, LD=5'b10100, ST=5'b10110) and WIDTH.
- One natural sub-module: datapath_reg (32-bit register with async clear and load enable), instantiated for all registers.
- The ALU stays inline.

Test Plan:
- clr=1 then 0 -> every register 0, OutportOut=0, bus=0 with no select active.
- MDRMDataIn=0x12, pulse Inports; then InportOut+r0ins for one cycle -> R0=0x00000012; R0out alone drives 0x12; R0out+BAOut drives 0.
- MDRMDataIn=0xB00001FF, Inports, then InportOut+IRins -> IR=0xB00001FF; Cout drives 0x000001FF. With IR=0x000C0000|opcode bits and IR[18]=1, Cout drives 0xFFFC0000.
- R0=0x12, IR.Rb=0 with add opcode, R0out+ALUen+ZLOins -> ZLO=0x24; then ZLOout+Outports -> OutportOut=0x24.
- PC=0: incPC+PCins for 3 cycles -> PC=3. PCout+MARins -> MAR=3. MDRRead+MDRins with MDRMDataIn=0xA00001FF -> MDR=0xA00001FF.
- Assert clr asynchronously between clock edges with registers loaded -> all registers clear before the next edge.

Source files
------------

// File: rtl/bus_datapath_pkg.sv
// Shared constants for the single-bus datapath: data width and ALU opcodes taken from IR[31:27].
package bus_datapath_pkg;

  localparam int unsigned WIDTH = 32;

  localparam logic [4:0] OpAdd = 5'b00011;
  localparam logic [4:0] OpSub = 5'b00100;
  localparam logic [4:0] OpAnd = 5'b00101;
  localparam logic [4:0] OpOr  = 5'b00110;
  localparam logic [4:0] OpShr = 5'b00111;
  localparam logic [4:0] OpShl = 5'b01001;
  localparam logic [4:0] OpNeg = 5'b10001;
  localparam logic [4:0] OpNot = 5'b10010;
  localparam logic [4:0] OpLd  = 5'b10100;
  localparam logic [4:0] OpSt  = 5'b10110;

endpackage

// File: rtl/bus_datapath_reg.sv
// Generic datapath register: load on enable, asynchronous active-high clear.
module datapath_reg #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (en_i) data_d = d_i;
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) data_q <= '0;
    else       data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/bus_datapath.sv
// Single-bus 32-bit CPU datapath: register file, HI/LO, Z, PC, IR, MAR, MDR, I/O ports and ALU
// around one shared bus. All strobes come from outside; there is no sequencing here.
module bus_datapath #(
  parameter int unsigned WIDTH = bus_datapath_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             MDRRead,
  input  logic             ALUen,
  input  logic             incPC,
  input  logic             BAOut,
  input  logic             R0out,  R1out,  R2out,  R3out,  R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out, R12out, R13out, R14out, R20out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             ZHIout,
  input  logic             ZLOout,
  input  logic             PCout,
  input  logic             MDRout,
  input  logic             InportOut,
  input  logic             Cout,
  input  logic             r0ins,  r1ins,  r2ins,  r3ins,  r4ins,  r5ins,  r6ins,  r7ins,
  input  logic             r8ins,  r9ins,  r10ins, r11ins, r12ins, r13ins, r14ins, r20ins,
  input  logic             HIins,
  input  logic             LOins,
  input  logic             ZHIins,
  input  logic             ZLOins,
  input  logic             PCins,
  input  logic             MDRins,
  input  logic             MARins,
  input  logic             Inports,
  input  logic             Outports,
  input  logic             IRins,
  input  logic [WIDTH-1:0] MDRMDataIn,
  output logic [WIDTH-1:0] OutportOut
);

  import bus_datapath_pkg::*;

  logic [15:0]        gpr_sel, gpr_ld;
  logic [WIDTH-1:0]   gpr_val [16];
  logic [WIDTH-1:0]   bus;
  logic [WIDTH-1:0]   hi_val, lo_val, zhi_val, zlo_val, pc_val, pc_d;
  logic [WIDTH-1:0]   ir_val, mar_val, mdr_val, mdr_d, inport_val, c_val;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [WIDTH:0]     alu_wide;
  logic [2*WIDTH-1:0] alu_res, z_src;

  // Index 15 of the register file is R20.
  assign gpr_sel = {R20out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign gpr_ld  = {r20ins, r14ins, r13ins, r12ins, r11ins, r10ins, r9ins, r8ins,
                    r7ins,  r6ins,  r5ins,  r4ins,  r3ins,  r2ins,  r1ins, r0ins};

  for (genvar i = 0; i < 16; i++) begin : g_gpr
    datapath_reg #(.Width(WIDTH)) u_gpr (
      .clk_i(clk), .clr_i(clr), .en_i(gpr_ld[i]), .d_i(bus), .q_o(gpr_val[i])
    );
  end

  assign c_val = {{(WIDTH-19){ir_val[18]}}, ir_val[18:0]};

  always_comb begin
    bus = '0;
    if (|gpr_sel) begin
      // Walk downward so the lowest-numbered active select wins.
      for (int i = 15; i >= 0; i--) begin
        if (gpr_sel[i]) bus = gpr_val[i];
      end
      if (gpr_sel[0] && BAOut) bus = '0;
    end else if (HIout)     bus = hi_val;
    else if (LOout)         bus = lo_val;
    else if (ZHIout)        bus = zhi_val;
    else if (ZLOout)        bus = zlo_val;
    else if (PCout)         bus = pc_val;
    else if (MDRout)        bus = mdr_val;
    else if (InportOut)     bus = inport_val;
    else if (Cout)          bus = c_val;
  end

  assign alu_a = gpr_val[ir_val[22:19]];
  assign alu_b = bus;

  // Add/sub keep the carry/borrow in bit WIDTH and sign-extend from there into the high word.
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    case (ir_val[31:27])
      OpSub: begin
        alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
        alu_res  = {{(WIDTH-1){alu_wide[WIDTH]}}, alu_wide};
      end
      OpAnd:   alu_res = {{WIDTH{1'b0}}, alu_a & alu_b};
      OpOr:    alu_res = {{WIDTH{1'b0}}, alu_a | alu_b};
      OpShr:   alu_res = {{WIDTH{1'b0}}, alu_a >> alu_b[4:0]};
      OpShl:   alu_res = {{WIDTH{1'b0}}, alu_a << alu_b[4:0]};
      OpNeg:   alu_res = {{WIDTH{1'b0}}, -alu_b};
      OpNot:   alu_res = {{WIDTH{1'b0}}, ~alu_b};
      default: begin
        alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res  = {{(WIDTH-1){alu_wide[WIDTH]}}, alu_wide};
      end
    endcase
  end

  assign z_src = ALUen ? alu_res : {{WIDTH{1'b0}}, bus};
  assign pc_d  = incPC ? pc_val + WIDTH'(1) : bus;
  assign mdr_d = MDRRead ? MDRMDataIn : bus;

  datapath_reg #(.Width(WIDTH)) u_hi (
    .clk_i(clk), .clr_i(clr), .en_i(HIins), .d_i(bus), .q_o(hi_val)
  );
  datapath_reg #(.Width(WIDTH)) u_lo (
    .clk_i(clk), .clr_i(clr), .en_i(LOins), .d_i(bus), .q_o(lo_val)
  );
  datapath_reg #(.Width(WIDTH)) u_zhi (
    .clk_i(clk), .clr_i(clr), .en_i(ZHIins), .d_i(z_src[2*WIDTH-1:WIDTH]), .q_o(zhi_val)
  );
  datapath_reg #(.Width(WIDTH)) u_zlo (
    .clk_i(clk), .clr_i(clr), .en_i(ZLOins), .d_i(z_src[WIDTH-1:0]), .q_o(zlo_val)
  );
  datapath_reg #(.Width(WIDTH)) u_pc (
    .clk_i(clk), .clr_i(clr), .en_i(PCins), .d_i(pc_d), .q_o(pc_val)
  );
  datapath_reg #(.Width(WIDTH)) u_ir (
    .clk_i(clk), .clr_i(clr), .en_i(IRins), .d_i(bus), .q_o(ir_val)
  );
  datapath_reg #(.Width(WIDTH)) u_mar (
    .clk_i(clk), .clr_i(clr), .en_i(MARins), .d_i(bus), .q_o(mar_val)
  );
  datapath_reg #(.Width(WIDTH)) u_mdr (
    .clk_i(clk), .clr_i(clr), .en_i(MDRins), .d_i(mdr_d), .q_o(mdr_val)
  );
  datapath_reg #(.Width(WIDTH)) u_inport (
    .clk_i(clk), .clr_i(clr), .en_i(Inports), .d_i(MDRMDataIn), .q_o(inport_val)
  );
  datapath_reg #(.Width(WIDTH)) u_outport (
    .clk_i(clk), .clr_i(clr), .en_i(Outports), .d_i(bus), .q_o(OutportOut)
  );

  // MAR feeds the memory interface of the surrounding CPU; IR[26:23] is unused by this ALU.
  logic unused_sig;
  assign unused_sig = ^{mar_val, ir_val[26:23]};

endmodule

// File: tb/tb_bus_datapath.sv
// Directed self-checking bench for bus_datapath; registers are observed through the bus.
module tb_bus_datapath;

  logic        clk = 1'b0;
  logic        clr;
  logic        MDRRead, ALUen, incPC, BAOut;
  logic [15:0] rout, rins;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, InportOut, Cout;
  logic        HIins, LOins, ZHIins, ZLOins, PCins, MDRins, MARins, Inports, Outports, IRins;
  logic [31:0] MDRMDataIn;
  logic [31:0] OutportOut;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_datapath #(.WIDTH(32)) dut (
    .clk(clk), .clr(clr), .MDRRead(MDRRead), .ALUen(ALUen), .incPC(incPC), .BAOut(BAOut),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R20out(rout[15]),
    .HIout(HIout), .LOout(LOout), .ZHIout(ZHIout), .ZLOout(ZLOout), .PCout(PCout),
    .MDRout(MDRout), .InportOut(InportOut), .Cout(Cout),
    .r0ins(rins[0]),   .r1ins(rins[1]),   .r2ins(rins[2]),   .r3ins(rins[3]),
    .r4ins(rins[4]),   .r5ins(rins[5]),   .r6ins(rins[6]),   .r7ins(rins[7]),
    .r8ins(rins[8]),   .r9ins(rins[9]),   .r10ins(rins[10]), .r11ins(rins[11]),
    .r12ins(rins[12]), .r13ins(rins[13]), .r14ins(rins[14]), .r20ins(rins[15]),
    .HIins(HIins), .LOins(LOins), .ZHIins(ZHIins), .ZLOins(ZLOins), .PCins(PCins),
    .MDRins(MDRins), .MARins(MARins), .Inports(Inports), .Outports(Outports), .IRins(IRins),
    .MDRMDataIn(MDRMDataIn), .OutportOut(OutportOut)
  );

  task automatic clear_ctrl();
    MDRRead = 0; ALUen = 0; incPC = 0; BAOut = 0; rout = '0; rins = '0;
    HIout = 0; LOout = 0; ZHIout = 0; ZLOout = 0; PCout = 0; MDRout = 0; InportOut = 0; Cout = 0;
    HIins = 0; LOins = 0; ZHIins = 0; ZLOins = 0; PCins = 0; MDRins = 0; MARins = 0;
    Inports = 0; Outports = 0; IRins = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k);
    case (k)
      0: HIout = 1;  1: LOout = 1;  2: ZHIout = 1;  3: ZLOout = 1;
      4: PCout = 1;  5: MDRout = 1; 6: InportOut = 1;
      default: Cout = 1;
    endcase
  endtask

  task automatic load_reg(input int idx, input logic [31:0] val);
    MDRMDataIn = val; Inports = 1; tick(); clear_ctrl();
    InportOut = 1; rins[idx] = 1; tick(); clear_ctrl();
  endtask

  task automatic load_ir(input logic [31:0] val);
    MDRMDataIn = val; Inports = 1; tick(); clear_ctrl();
    InportOut = 1; IRins = 1; tick(); clear_ctrl();
  endtask

  task automatic test_reset();
    clear_ctrl(); MDRMDataIn = '0; clr = 1;
    tick(); tick();
    clr = 0; #2;
    checks++;
    if (OutportOut !== 32'h0) begin
      failures++; $display("FAIL reset_outport got=%h want=%h", OutportOut, 32'h0);
    end
    checks++;
    if (dut.bus !== 32'h0) begin
      failures++; $display("FAIL reset_bus_idle got=%h want=%h", dut.bus, 32'h0);
    end
    for (int i = 0; i < 16; i++) begin
      rout = '0; rout[i] = 1; #1;
      checks++;
      if (dut.bus !== 32'h0) begin
        failures++; $display("FAIL reset_gpr%0d got=%h want=%h", i, dut.bus, 32'h0);
      end
    end
    clear_ctrl();
    for (int k = 0; k < 8; k++) begin
      clear_ctrl(); set_src(k); #1;
      checks++;
      if (dut.bus !== 32'h0) begin
        failures++; $display("FAIL reset_src%0d got=%h want=%h", k, dut.bus, 32'h0);
      end
    end
    clear_ctrl();
  endtask

  task automatic test_inport_r0();
    load_reg(0, 32'h12);
    rout[0] = 1; #1;
    checks++;
    if (dut.bus !== 32'h12) begin
      failures++; $display("FAIL r0_out got=%h want=%h", dut.bus, 32'h12);
    end
    BAOut = 1; #1;
    checks++;
    if (dut.bus !== 32'h0) begin
      failures++; $display("FAIL r0_baout got=%h want=%h", dut.bus, 32'h0);
    end
    BAOut = 0; PCout = 1; InportOut = 1; #1;
    checks++;
    if (dut.bus !== 32'h12) begin
      failures++; $display("FAIL bus_priority got=%h want=%h", dut.bus, 32'h12);
    end
    clear_ctrl();
  endtask

  task automatic test_ir_const();
    load_ir(32'hB00001FF);
    Cout = 1; #1;
    checks++;
    if (dut.bus !== 32'h000001FF) begin
      failures++; $display("FAIL cout_pos got=%h want=%h", dut.bus, 32'h000001FF);
    end
    clear_ctrl();
    load_ir(32'h180C0000);
    Cout = 1; #1;
    checks++;
    if (dut.bus !== 32'hFFFC0000) begin
      failures++; $display("FAIL cout_neg got=%h want=%h", dut.bus, 32'hFFFC0000);
    end
    clear_ctrl();
  endtask

  task automatic test_alu_add();
    load_ir(32'h18000000);
    rout[0] = 1; ALUen = 1; ZLOins = 1; tick(); clear_ctrl();
    ZLOout = 1; Outports = 1; tick(); clear_ctrl();
    checks++;
    if (OutportOut !== 32'h24) begin
      failures++; $display("FAIL add_outport got=%h want=%h", OutportOut, 32'h24);
    end
    // ALUen low: Z takes the bus value directly.
    rout[0] = 1; ZLOins = 1; ZHIins = 1; tick(); clear_ctrl();
    ZLOout = 1; #1;
    checks++;
    if (dut.bus !== 32'h12) begin
      failures++; $display("FAIL zlo_bypass got=%h want=%h", dut.bus, 32'h12);
    end
    clear_ctrl(); ZHIout = 1; #1;
    checks++;
    if (dut.bus !== 32'h0) begin
      failures++; $display("FAIL zhi_bypass got=%h want=%h", dut.bus, 32'h0);
    end
    clear_ctrl();
  endtask

  task automatic test_alu_ops();
    logic [31:0] ir_tab  [9] = '{32'h20080000, 32'h28080000, 32'h30080000, 32'h38080000,
                                 32'h48080000, 32'h88080000, 32'h90080000, 32'hA0080000,
                                 32'hB0080000};
    int          src_tab [9] = '{0, 0, 0, 2, 2, 0, 0, 0, 0};
    logic [31:0] exp_tab [9] = '{32'h000000DE, 32'h00000010, 32'h000000F2, 32'h0000000F,
                                 32'h00000F00, 32'hFFFFFFEE, 32'hFFFFFFED, 32'h00000102,
                                 32'h00000102};
    load_reg(1, 32'hF0);
    load_reg(2, 32'h4);
    for (int i = 0; i < 9; i++) begin
      load_ir(ir_tab[i]);
      rout[src_tab[i]] = 1; ALUen = 1; ZLOins = 1; ZHIins = 1; tick(); clear_ctrl();
      ZLOout = 1; #1;
      checks++;
      if (dut.bus !== exp_tab[i]) begin
        failures++; $display("FAIL alu_lo_%0d got=%h want=%h", i, dut.bus, exp_tab[i]);
      end
      clear_ctrl(); ZHIout = 1; #1;
      checks++;
      if (dut.bus !== 32'h0) begin
        failures++; $display("FAIL alu_hi_%0d got=%h want=%h", i, dut.bus, 32'h0);
      end
      clear_ctrl();
    end
  endtask

  task automatic test_pc_mar_mdr();
    for (int i = 0; i < 3; i++) begin
      incPC = 1; PCins = 1; tick();
    end
    clear_ctrl(); PCout = 1; #1;
    checks++;
    if (dut.bus !== 32'h3) begin
      failures++; $display("FAIL pc_inc got=%h want=%h", dut.bus, 32'h3);
    end
    MARins = 1; tick(); clear_ctrl();
    checks++;
    if (dut.mar_val !== 32'h3) begin
      failures++; $display("FAIL mar_load got=%h want=%h", dut.mar_val, 32'h3);
    end
    MDRMDataIn = 32'hA00001FF; MDRRead = 1; MDRins = 1; tick(); clear_ctrl();
    MDRout = 1; #1;
    checks++;
    if (dut.bus !== 32'hA00001FF) begin
      failures++; $display("FAIL mdr_mem got=%h want=%h", dut.bus, 32'hA00001FF);
    end
    clear_ctrl(); incPC = 1; tick(); clear_ctrl();
    PCout = 1; #1;
    checks++;
    if (dut.bus !== 32'h3) begin
      failures++; $display("FAIL incpc_alone got=%h want=%h", dut.bus, 32'h3);
    end
    MDRins = 1; tick(); clear_ctrl();
    MDRout = 1; #1;
    checks++;
    if (dut.bus !== 32'h3) begin
      failures++; $display("FAIL mdr_bus got=%h want=%h", dut.bus, 32'h3);
    end
    clear_ctrl();
  endtask

  task automatic test_back_to_back();
    PCout = 1; PCins = 1; incPC = 1; #1;
    checks++;
    if (dut.bus !== 32'h3) begin
      failures++; $display("FAIL rw_old got=%h want=%h", dut.bus, 32'h3);
    end
    tick(); clear_ctrl();
    PCout = 1; #1;
    checks++;
    if (dut.bus !== 32'h4) begin
      failures++; $display("FAIL rw_new got=%h want=%h", dut.bus, 32'h4);
    end
    clear_ctrl();
    rout[0] = 1; PCins = 1; tick(); clear_ctrl();
    PCout = 1; #1;
    checks++;
    if (dut.bus !== 32'h12) begin
      failures++; $display("FAIL pc_from_bus got=%h want=%h", dut.bus, 32'h12);
    end
    clear_ctrl();
  endtask

  task automatic test_async_clr();
    rout[0] = 1;
    @(posedge clk); #3;
    clr = 1; #1;
    checks++;
    if (OutportOut !== 32'h0) begin
      failures++; $display("FAIL clr_outport got=%h want=%h", OutportOut, 32'h0);
    end
    checks++;
    if (dut.bus !== 32'h0) begin
      failures++; $display("FAIL clr_r0 got=%h want=%h", dut.bus, 32'h0);
    end
    clear_ctrl(); PCout = 1; #1;
    checks++;
    if (dut.bus !== 32'h0) begin
      failures++; $display("FAIL clr_pc got=%h want=%h", dut.bus, 32'h0);
    end
    clear_ctrl(); MDRout = 1; #1;
    checks++;
    if (dut.bus !== 32'h0) begin
      failures++; $display("FAIL clr_mdr got=%h want=%h", dut.bus, 32'h0);
    end
    checks++;
    if (dut.mar_val !== 32'h0) begin
      failures++; $display("FAIL clr_mar got=%h want=%h", dut.mar_val, 32'h0);
    end
    clear_ctrl();
    // Loads across an edge while clr is held must not take.
    MDRMDataIn = 32'h55; Inports = 1; Cout = 1; Outports = 1; tick();
    clear_ctrl(); InportOut = 1; #1;
    checks++;
    if (dut.bus !== 32'h0) begin
      failures++; $display("FAIL clr_hold_inport got=%h want=%h", dut.bus, 32'h0);
    end
    clr = 0;
    clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_inport_r0();
    test_ir_const();
    test_alu_add();
    test_alu_ops();
    test_pc_mar_mdr();
    test_back_to_back();
    test_async_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
